// File: rtl/power_switch_ack_emu.sv
// Per-domain power-switch acknowledge emulator: programmable on/off latency, abort, busy/done status.
// Optional freeze input fault_stuck_i is compiled in with POWER_SWITCH_EMU_FAULT_EN.
module power_switch_ack_emu #(
  parameter int NUM_DOMAINS = 3,
  parameter int CNT_W       = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_DOMAINS-1:0]       switch_n_i,
  input  logic [NUM_DOMAINS*CNT_W-1:0] on_lat_i,
  input  logic [NUM_DOMAINS*CNT_W-1:0] off_lat_i,
`ifdef POWER_SWITCH_EMU_FAULT_EN
  input  logic [NUM_DOMAINS-1:0]       fault_stuck_i,
`endif
  output logic [NUM_DOMAINS-1:0]       ack_n_o,
  output logic [NUM_DOMAINS-1:0]       busy_o,
  output logic [NUM_DOMAINS-1:0]       done_o
);

  typedef enum logic [1:0] {
    ST_ON,
    ST_RAMP_DN,
    ST_OFF,
    ST_RAMP_UP
  } state_e;

  logic [NUM_DOMAINS-1:0] freeze;

`ifdef POWER_SWITCH_EMU_FAULT_EN
  assign freeze = fault_stuck_i;
`else
  assign freeze = '0;
`endif

  for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_dom
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] on_lat, off_lat;
    logic [CNT_W-1:0] on_load, off_load;
    logic             ack_n, busy;

    // Load value is L-1 with L = max(lat, 1), so a latency of 0 behaves as 1.
    always_comb begin
      on_lat   = on_lat_i[d*CNT_W +: CNT_W];
      off_lat  = off_lat_i[d*CNT_W +: CNT_W];
      on_load  = (on_lat == '0)  ? '0 : on_lat - CNT_W'(1);
      off_load = (off_lat == '0) ? '0 : off_lat - CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= ST_ON;
        cnt_q   <= '0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        done_q  <= done_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      if (!freeze[d]) begin
        case (state_q)
          ST_ON: begin
            if (switch_n_i[d]) begin
              state_d = ST_RAMP_DN;
              cnt_d   = off_load;
            end
          end
          ST_RAMP_DN: begin
            if (!switch_n_i[d]) begin
              state_d = ST_ON;
            end else if (cnt_q == '0) begin
              state_d = ST_OFF;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
          ST_OFF: begin
            if (!switch_n_i[d]) begin
              state_d = ST_RAMP_UP;
              cnt_d   = on_load;
            end
          end
          ST_RAMP_UP: begin
            if (switch_n_i[d]) begin
              state_d = ST_OFF;
            end else if (cnt_q == '0) begin
              state_d = ST_ON;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
          default: begin
            state_d = ST_ON;
            cnt_d   = '0;
          end
        endcase
      end
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    always_comb begin
      ack_n = (state_q == ST_OFF) || (state_q == ST_RAMP_UP);
      busy  = (state_q == ST_RAMP_DN) || (state_q == ST_RAMP_UP);
    end

    assign ack_n_o[d] = ack_n;
    assign busy_o[d]  = busy;
    assign done_o[d]  = done_q;
  end

endmodule

// File: tb/tb_power_switch_ack_emu.sv
// Randomized and directed bench for power_switch_ack_emu against a deadline-based reference model.
module tb_power_switch_ack_emu;
  localparam int N = 3;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   sw;
  logic [N*W-1:0] on_lat, off_lat;
  logic [N-1:0]   stuck;
  logic [N-1:0]   ack, busy, done;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  power_switch_ack_emu #(.NUM_DOMAINS(N), .CNT_W(W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .switch_n_i   (sw),
    .on_lat_i     (on_lat),
    .off_lat_i    (off_lat),
`ifdef POWER_SWITCH_EMU_FAULT_EN
    .fault_stuck_i(stuck),
`endif
    .ack_n_o      (ack),
    .busy_o       (busy),
    .done_o       (done)
  );

  // Reference model: each ramp is a deadline in absolute edge count.
  bit m_ack[N];
  bit m_ramp[N];
  bit m_done[N];
  int m_dl[N];
  int edge_no;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int eff_lat(input logic [W-1:0] v);
    return (v == 0) ? 1 : int'(v);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < N; d++) begin
      m_ack[d] = 0; m_ramp[d] = 0; m_done[d] = 0; m_dl[d] = 0;
    end
  endtask

  task automatic model_edge();
    bit frz;
    edge_no++;
    for (int d = 0; d < N; d++) begin
      m_done[d] = 0;
`ifdef POWER_SWITCH_EMU_FAULT_EN
      frz = stuck[d];
`else
      frz = 0;
`endif
      if (frz) begin
        if (m_ramp[d]) m_dl[d]++;
      end else if (!m_ramp[d]) begin
        if (sw[d] != m_ack[d]) begin
          m_ramp[d] = 1;
          m_dl[d]   = edge_no + eff_lat(sw[d] ? off_lat[d*W +: W] : on_lat[d*W +: W]);
        end
      end else if (sw[d] == m_ack[d]) begin
        m_ramp[d] = 0;
      end else if (edge_no == m_dl[d]) begin
        m_ack[d]  = ~m_ack[d];
        m_ramp[d] = 0;
        m_done[d] = 1;
      end
    end
  endtask

  task automatic compare(input string ph);
    logic [N-1:0] ea, eb, ed;
    for (int d = 0; d < N; d++) begin
      ea[d] = m_ack[d]; eb[d] = m_ramp[d]; ed[d] = m_done[d];
    end
    chk({ph, ".ack"},  32'(ack),  32'(ea));
    chk({ph, ".busy"}, 32'(busy), 32'(eb));
    chk({ph, ".done"}, 32'(done), 32'(ed));
  endtask

  task automatic step(input string ph, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!rst) model_edge();
      #1;
      compare(ph);
    end
  endtask

  task automatic set_lat(input int d, input int on_v, input int off_v);
    on_lat[d*W +: W]  = W'(on_v);
    off_lat[d*W +: W] = W'(off_v);
  endtask

  initial begin
    rst = 1'b1; sw = '0; on_lat = '0; off_lat = '0; stuck = '0;
    edge_no = 0;
    model_reset();
    #12;
    compare("reset");
    step("reset_hold", 1);
    rst = 1'b0;
    step("idle", 20);

    // Domain 0: off latency 15, then on latency 4
    set_lat(0, 4, 15);
    sw[0] = 1'b1;
    step("d0_off15", 18);
    sw[0] = 1'b0;
    step("d0_on4", 6);

    // Latency boundaries 0, 1, 255
    set_lat(0, 1, 0);
    sw[0] = 1'b1; step("lat0", 3);
    sw[0] = 1'b0; step("lat0_back", 3);
    set_lat(0, 1, 1);
    sw[0] = 1'b1; step("lat1", 3);
    sw[0] = 1'b0; step("lat1_back", 3);
    set_lat(0, 2, 255);
    sw[0] = 1'b1; step("lat255", 258);
    sw[0] = 1'b0; step("lat255_back", 4);

    // Domain 1 abort at k+5, then full re-request
    set_lat(1, 2, 10);
    sw[1] = 1'b1; step("d1_ramp", 5);
    sw[1] = 1'b0; step("d1_abort", 3);
    sw[1] = 1'b1; step("d1_rereq", 13);
    sw[1] = 1'b0; step("d1_back", 4);

    // Parallel domains with latencies 3/7/12
    set_lat(0, 2, 3); set_lat(1, 2, 7); set_lat(2, 2, 12);
    sw = '1;
    step("par", 14);
    sw = '0;
    step("par_back", 4);

`ifdef POWER_SWITCH_EMU_FAULT_EN
    set_lat(2, 2, 8);
    sw[2] = 1'b1; step("stuck_pre", 3);
    stuck[2] = 1'b1; step("stuck_hold", 5);
    stuck[2] = 1'b0; step("stuck_post", 8);
    sw[2] = 1'b0; step("stuck_back", 4);
`endif

    // Asynchronous reset mid-ramp, with a request held across release
    set_lat(0, 5, 9); set_lat(1, 5, 9); set_lat(2, 5, 9);
    sw = 3'b101;
    step("pre_rst", 4);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare("async_rst");
    step("rst_hold", 2);
    rst = 1'b0;
    step("rst_release", 12);

    // Randomized traffic; latencies change every cycle to cover load-edge sampling
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < N; d++) begin
        if ($urandom_range(0, 11) == 0) sw[d] = ~sw[d];
        if ($urandom_range(0, 39) == 0) set_lat(d, $urandom_range(0, 255), $urandom_range(0, 255));
        else set_lat(d, $urandom_range(0, 12), $urandom_range(0, 12));
`ifdef POWER_SWITCH_EMU_FAULT_EN
        stuck[d] = ($urandom_range(0, 9) == 0);
`endif
      end
      step("rand", 1);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
